// File: rtl/mig_tg_pkg.sv
// Shared types and constants for the MIG write/read-back traffic checker.
package mig_tg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitCal,
        StWrite,
        StRead,
        StDrain,
        StDone
    } tg_state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_WALK1 = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_ADDR  = 2'd3;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois form: the bit shifted out decides whether the taps are applied.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mig_pattern_gen.sv
// Regenerates the per-beat data pattern; load restarts at beat 0, step advances one beat.
module mig_pattern_gen
    import mig_tg_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 29,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned LANES = DATA_W / 32;

    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_lfsr;
    logic [CNT_W-1:0]  w_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode <= MODE_INC;
            r_idx  <= '0;
            r_addr <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_idx  <= '0;
            r_addr <= i_base_addr;
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_idx  <= r_idx + CNT_W'(1);
            r_addr <= r_addr + ADDR_W'(ADDR_STEP);
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_bit = r_idx % CNT_W'(DATA_W);

    always_comb begin
        o_data = '0;
        unique case (r_mode)
            MODE_INC:   o_data = {LANES{32'(r_idx)}};
            MODE_WALK1: o_data = DATA_W'(1) << w_bit;
            MODE_LFSR:  o_data = {LANES{r_lfsr}};
            MODE_ADDR:  o_data = {LANES{32'(r_addr)}};
        endcase
    end

endmodule

// File: rtl/mig_traffic_checker.sv
// Write/read-back traffic generator and checker on the MIG 7-series app interface.
// Define MIG_TG_ERR_LOG_EN to add first-mismatch capture ports (err_addr/err_exp/err_got).
module mig_traffic_checker
    import mig_tg_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 29,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic                  i_ui_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [CNT_W-1:0]      i_num_bursts,
    input  logic                  i_init_calib_complete,
    input  logic                  i_app_rdy,
    input  logic                  i_app_wdf_rdy,
    output logic                  o_app_en,
    output logic [2:0]            o_app_cmd,
    output logic [ADDR_W-1:0]     o_app_addr,
    output logic [DATA_W-1:0]     o_app_wdf_data,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    output logic [DATA_W/8-1:0]   o_app_wdf_mask,
    input  logic [DATA_W-1:0]     i_app_rd_data,
    input  logic                  i_app_rd_data_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [CNT_W-1:0]      o_err_count
`ifdef MIG_TG_ERR_LOG_EN
    ,
    output logic [ADDR_W-1:0]     o_err_addr,
    output logic [DATA_W-1:0]     o_err_exp,
    output logic [DATA_W-1:0]     o_err_got
`endif
);

    tg_state_e         r_state;
    logic              r_app_en;
    logic [2:0]        r_app_cmd;
    logic [ADDR_W-1:0] r_app_addr;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_num;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_ret_cnt;

    logic              w_idle;
    logic              w_run_start;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ret;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_exp_data;

    assign w_idle      = (r_state == StIdle) || (r_state == StDone);
    assign w_run_start = w_idle && i_start && (i_num_bursts != '0);
    assign w_wr_acc    = (r_state == StWrite) && i_app_rdy && i_app_wdf_rdy;
    assign w_rd_acc    = (r_state == StRead) && i_app_rdy;
    // Only the first num_bursts returns of a run are compared; extras are dropped.
    assign w_ret       = ((r_state == StRead) || (r_state == StDrain)) && i_app_rd_data_valid &&
                         (r_ret_cnt != r_num);
    assign w_mismatch  = w_ret && (i_app_rd_data != w_exp_data);

    mig_pattern_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_wr_gen (
        .i_clk       (i_ui_clk),
        .i_rst       (i_sys_rst),
        .i_load      (w_run_start),
        .i_step      (w_wr_acc),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .o_data      (w_wr_data)
    );

    mig_pattern_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_exp_gen (
        .i_clk       (i_ui_clk),
        .i_rst       (i_sys_rst),
        .i_load      (w_run_start),
        .i_step      (w_ret),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .o_data      (w_exp_data)
    );

    always_ff @(posedge i_ui_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state     <= StIdle;
            r_app_en    <= 1'b0;
            r_app_cmd   <= CMD_WR;
            r_app_addr  <= '0;
            r_wren      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_num       <= '0;
            r_base      <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_ret) begin
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                if (w_mismatch) begin
                    r_error <= 1'b1;
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + CNT_W'(1);
                    end
                end
            end

            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        if (i_num_bursts == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_num       <= i_num_bursts;
                            r_base      <= i_base_addr;
                            r_app_addr  <= i_base_addr;
                            r_wr_cnt    <= '0;
                            r_rd_cnt    <= '0;
                            r_ret_cnt   <= '0;
                            r_error     <= 1'b0;
                            r_err_count <= '0;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                            if (i_init_calib_complete) begin
                                r_state   <= StWrite;
                                r_app_en  <= 1'b1;
                                r_wren    <= 1'b1;
                                r_app_cmd <= CMD_WR;
                            end else begin
                                r_state <= StWaitCal;
                            end
                        end
                    end
                end
                StWaitCal: begin
                    if (i_init_calib_complete) begin
                        r_state   <= StWrite;
                        r_app_en  <= 1'b1;
                        r_wren    <= 1'b1;
                        r_app_cmd <= CMD_WR;
                    end
                end
                StWrite: begin
                    if (w_wr_acc) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        if (r_wr_cnt == r_num - CNT_W'(1)) begin
                            r_state    <= StRead;
                            r_wren     <= 1'b0;
                            r_app_cmd  <= CMD_RD;
                            r_app_addr <= r_base;
                        end else begin
                            r_app_addr <= r_app_addr + ADDR_W'(ADDR_STEP);
                        end
                    end
                end
                StRead: begin
                    if (w_rd_acc) begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        if (r_rd_cnt == r_num - CNT_W'(1)) begin
                            r_state  <= StDrain;
                            r_app_en <= 1'b0;
                        end else begin
                            r_app_addr <= r_app_addr + ADDR_W'(ADDR_STEP);
                        end
                    end
                end
                StDrain: begin
                    if (r_ret_cnt == r_num) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_app_en       = r_app_en;
    assign o_app_cmd      = r_app_cmd;
    assign o_app_addr     = r_app_addr;
    assign o_app_wdf_data = w_wr_data;
    assign o_app_wdf_wren = r_wren;
    assign o_app_wdf_end  = r_wren;
    assign o_app_wdf_mask = '0;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_err_count    = r_err_count;

`ifdef MIG_TG_ERR_LOG_EN
    logic [ADDR_W-1:0] r_exp_addr;
    logic [ADDR_W-1:0] r_err_addr;
    logic [DATA_W-1:0] r_err_exp;
    logic [DATA_W-1:0] r_err_got;

    always_ff @(posedge i_ui_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_exp_addr <= '0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (w_idle && i_start) begin
            r_exp_addr <= i_base_addr;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (w_ret) begin
            r_exp_addr <= r_exp_addr + ADDR_W'(ADDR_STEP);
            if (w_mismatch && !r_error) begin
                r_err_addr <= r_exp_addr;
                r_err_exp  <= w_exp_data;
                r_err_got  <= i_app_rd_data;
            end
        end
    end

    assign o_err_addr = r_err_addr;
    assign o_err_exp  = r_err_exp;
    assign o_err_got  = r_err_got;
`endif

endmodule
